// File: rtl/common_fifo_pkg.sv
// Shared constants and helpers for the common FIFO family.
// Mode strings, count sizing and default flag thresholds.
package common_fifo_pkg;

    localparam string FIFO_TRUE  = "TRUE";
    localparam string FIFO_FALSE = "FALSE";

    // almost_full default sits this many words below DEPTH
    localparam int FIFO_AF_MARGIN = 4;
    localparam int FIFO_AE_THRESH = 4;

    // Count must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int fifo_cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/common_sync_fifo_ram.sv
// Inferred simple dual-port RAM: synchronous write, registered read with
// optional second output register. The array itself is never reset.
module common_sync_fifo_ram
    import common_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 9,
    parameter string OUTPUT_REG = FIFO_TRUE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  oce,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam bit OREG = (OUTPUT_REG == FIFO_TRUE);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout1;
    logic [DATA_WIDTH-1:0] dout2;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Output registers hold when not enabled so rdata stays stable between reads.
    always_ff @(posedge clk) begin
        if (rst)
            dout1 <= '0;
        else if (re)
            dout1 <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            dout2 <= '0;
        else if (oce)
            dout2 <= dout1;
    end

    assign rdata = OREG ? dout2 : dout1;

endmodule

// File: rtl/common_sync_fifo.sv
// Single-clock RAM FIFO with count, registered flags, overflow/underflow
// pulses and selectable standard or first-word-fall-through read mode.
module common_sync_fifo
    import common_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH          = 8,
    parameter int    ADDR_WIDTH          = 9,
    parameter string OUTPUT_REG          = FIFO_TRUE,
    parameter string FWFT                = FIFO_FALSE,
    parameter int    ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - FIFO_AF_MARGIN,
    parameter int    ALMOST_EMPTY_THRESH = FIFO_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int            CW        = fifo_cnt_w(ADDR_WIDTH);
    localparam int            STAGES    = (OUTPUT_REG == FIFO_TRUE) ? 2 : 1;
    localparam bit            FWFT_MODE = (FWFT == FIFO_TRUE);
    localparam logic [CW-1:0] DEPTH_C   = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C      = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_C      = CW'(ALMOST_EMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [CW-1:0]         avail;
    logic [CW-1:0]         avail_nxt;
    logic [CW-1:0]         cnt_nxt;
    logic                  empty_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  issue;
    logic                  ram_re;
    logic                  ram_oce;

    // vld_pipe[0]: read request registered (address stage)
    // vld_pipe[1..STAGES]: RAM output registers; the last one is the output stage.
    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] rdy;

    // In FWFT mode "empty" means the output stage holds nothing yet.
    assign empty  = FWFT_MODE ? !vld_pipe[STAGES] : empty_q;
    assign rvalid = vld_pipe[STAGES];

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Stage k may take new content if it is empty or its content moves on.
    // Standard mode never stalls; FWFT stalls only on an unpopped output word.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = FWFT_MODE ? (!vld_pipe[STAGES] || rd_acc) : 1'b1;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    // FWFT prefetches whenever RAM holds unrequested words and the pipe has room.
    assign issue = FWFT_MODE ? ((avail != '0) && rdy[0]) : rd_acc;

    assign cnt_nxt   = count + CW'(wr_acc) - CW'(rd_acc);
    assign avail_nxt = avail + CW'(wr_acc) - CW'(issue);

    assign ram_re = vld_pipe[0] && rdy[1];

    generate
        if (STAGES == 2) begin : g_oce
            assign ram_oce = vld_pipe[1] && rdy[2];
        end else begin : g_no_oce
            assign ram_oce = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            raddr_q      <= '0;
            count        <= '0;
            avail        <= '0;
            full         <= 1'b0;
            empty_q      <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (issue) begin
                rptr    <= rptr + 1'b1;
                raddr_q <= rptr;
            end
            count        <= cnt_nxt;
            avail        <= avail_nxt;
            full         <= (cnt_nxt == DEPTH_C);
            empty_q      <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= AF_C);
            almost_empty <= (cnt_nxt <= AE_C);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (rdy[0])
                vld_pipe[0] <= issue;
            for (int k = 1; k <= STAGES; k++)
                if (rdy[k])
                    vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    common_sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (raddr_q),
        .oce   (ram_oce),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_common_sync_fifo.sv
// Scoreboard bench: one standard-mode FIFO (OUTPUT_REG TRUE) and one FWFT
// FIFO (OUTPUT_REG FALSE) driven side by side and checked every cycle.
module tb_common_sync_fifo;

    localparam int DEPTH = 512;

    typedef struct {
        logic [7:0] data;
        int         t;
    } ent_t;

    logic clk;
    logic rst;

    logic       s_wr_en, s_rd_en, f_wr_en, f_rd_en;
    logic [7:0] s_wdata, f_wdata, s_rdata, f_rdata;
    logic       s_full, s_af, s_ovf, s_rvalid, s_empty, s_ae, s_unf;
    logic       f_full, f_af, f_ovf, f_rvalid, f_empty, f_ae, f_unf;
    logic [9:0] s_count, f_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [7:0] s_q[$];
    ent_t       s_sb[$];
    logic [7:0] s_last;
    ent_t       f_q[$];
    int         f_last_pop;

    common_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (9), .OUTPUT_REG ("TRUE"), .FWFT ("FALSE"),
        .ALMOST_FULL_THRESH (508), .ALMOST_EMPTY_THRESH (4)
    ) u_std (
        .clk (clk), .rst (rst),
        .wr_en (s_wr_en), .wdata (s_wdata), .full (s_full), .almost_full (s_af),
        .overflow (s_ovf), .rd_en (s_rd_en), .rdata (s_rdata), .rvalid (s_rvalid),
        .empty (s_empty), .almost_empty (s_ae), .underflow (s_unf), .count (s_count)
    );

    common_sync_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (9), .OUTPUT_REG ("FALSE"), .FWFT ("TRUE"),
        .ALMOST_FULL_THRESH (508), .ALMOST_EMPTY_THRESH (4)
    ) u_fwft (
        .clk (clk), .rst (rst),
        .wr_en (f_wr_en), .wdata (f_wdata), .full (f_full), .almost_full (f_af),
        .overflow (f_ovf), .rd_en (f_rd_en), .rdata (f_rdata), .rvalid (f_rvalid),
        .empty (f_empty), .almost_empty (f_ae), .underflow (f_unf), .count (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, act, exp);
        end
    endtask

    // Head word is visible two edges after its write, and no earlier than the
    // edge that popped its predecessor.
    function automatic bit f_visible(input int e);
        int a;
        if (f_q.size() == 0)
            return 1'b0;
        a = f_q[0].t + 2;
        if (f_last_pop > a)
            a = f_last_pop;
        return a <= e;
    endfunction

    task automatic tick();
        bit s_w, s_r, s_ov, s_un, s_rv;
        bit f_w, f_r, f_ov, f_un, f_vis;
        int n;
        ent_t e;
        s_w = 0; s_r = 0; s_ov = 0; s_un = 0;
        f_w = 0; f_r = 0; f_ov = 0; f_un = 0;
        if (!rst) begin
            s_w   = s_wr_en && (s_q.size() < DEPTH);
            s_r   = s_rd_en && (s_q.size() != 0);
            s_ov  = s_wr_en && (s_q.size() == DEPTH);
            s_un  = s_rd_en && (s_q.size() == 0);
            f_vis = f_visible(edge_n);
            f_r   = f_rd_en && f_vis;
            f_un  = f_rd_en && !f_vis;
            f_w   = f_wr_en && (f_q.size() < DEPTH);
            f_ov  = f_wr_en && (f_q.size() == DEPTH);
        end
        @(posedge clk);
        edge_n++;
        if (rst) begin
            s_q.delete(); s_sb.delete(); s_last = '0;
            f_q.delete(); f_last_pop = 0;
        end else begin
            if (s_r) begin
                e.data = s_q.pop_front();
                e.t    = edge_n + 2;
                s_sb.push_back(e);
            end
            if (s_w)
                s_q.push_back(s_wdata);
            if (f_r) begin
                void'(f_q.pop_front());
                f_last_pop = edge_n;
            end
            if (f_w) begin
                e.data = f_wdata;
                e.t    = edge_n;
                f_q.push_back(e);
            end
        end
        #1;
        s_rv = (s_sb.size() != 0) && (s_sb[0].t == edge_n);
        if (s_rv) begin
            s_last = s_sb[0].data;
            void'(s_sb.pop_front());
        end
        n = s_q.size();
        chk("s_rvalid", s_rvalid, s_rv);
        chk("s_rdata", s_rdata, s_last);
        chk("s_count", s_count, n);
        chk("s_full", s_full, n == DEPTH);
        chk("s_empty", s_empty, n == 0);
        chk("s_almost_full", s_af, n >= 508);
        chk("s_almost_empty", s_ae, n <= 4);
        chk("s_overflow", s_ovf, s_ov);
        chk("s_underflow", s_unf, s_un);
        f_vis = f_visible(edge_n);
        n = f_q.size();
        chk("f_rvalid", f_rvalid, f_vis);
        chk("f_empty", f_empty, !f_vis);
        if (f_vis)
            chk("f_rdata", f_rdata, f_q[0].data);
        chk("f_count", f_count, n);
        chk("f_full", f_full, n == DEPTH);
        chk("f_almost_full", f_af, n >= 508);
        chk("f_almost_empty", f_ae, n <= 4);
        chk("f_overflow", f_ovf, f_ov);
        chk("f_underflow", f_unf, f_un);
    endtask

    task automatic s_op(input bit wr, input logic [7:0] wd, input bit rd);
        s_wr_en = wr; s_wdata = wd; s_rd_en = rd;
        tick();
        s_wr_en = 0; s_rd_en = 0;
    endtask

    task automatic f_op(input bit wr, input logic [7:0] wd, input bit rd);
        f_wr_en = wr; f_wdata = wd; f_rd_en = rd;
        tick();
        f_wr_en = 0; f_rd_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1;
        s_wr_en = 0; s_rd_en = 0; s_wdata = '0;
        f_wr_en = 0; f_rd_en = 0; f_wdata = '0;
        s_last = '0; f_last_pop = 0;
        idle(2);
        chk("rst_s_rdata", s_rdata, 8'h00);
        chk("rst_f_rdata", f_rdata, 8'h00);
        rst = 0;
        idle(1);

        // standard: 4 writes then 4 reads, 2-cycle read latency
        for (int i = 0; i < 4; i++) s_op(1, 8'hA1 + 8'(i), 0);
        for (int i = 0; i < 4; i++) s_op(0, 8'h00, 1);
        idle(3);

        // fill past full, drain; second pass exercises pointer wrap
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) s_op(1, 8'(i) ^ (p != 0 ? 8'h5A : 8'h00), 0);
            s_op(1, 8'hEE, 0);
            for (int i = 0; i < DEPTH; i++) s_op(0, 8'h00, 1);
            idle(3);
        end

        // simultaneous read/write at full, then at empty
        for (int i = 0; i < DEPTH; i++) s_op(1, 8'(i * 3), 0);
        s_op(1, 8'h77, 1);
        for (int i = 0; i < DEPTH - 1; i++) s_op(0, 8'h00, 1);
        idle(3);
        s_op(1, 8'h99, 1);
        s_op(0, 8'h00, 1);
        idle(3);

        // reset with reads in flight
        for (int i = 0; i < 8; i++) s_op(1, 8'hB0 + 8'(i), 0);
        for (int i = 0; i < 3; i++) s_op(0, 8'h00, 1);
        rst = 1;
        tick();
        rst = 0;
        idle(4);

        // FWFT: single word into empty FIFO
        f_op(1, 8'h55, 0);
        idle(3);
        f_op(0, 8'h00, 1);
        idle(2);

        // FWFT: pop attempts while the first word is still being prefetched
        f_op(1, 8'hC3, 1);
        f_op(0, 8'h00, 1);
        idle(2);
        f_op(0, 8'h00, 1);
        idle(2);

        // FWFT: 16-word burst popped back to back
        for (int i = 0; i < 16; i++) f_op(1, 8'h10 + 8'(i), 0);
        idle(3);
        for (int i = 0; i < 16; i++) f_op(0, 8'h00, 1);
        f_op(0, 8'h00, 1);
        idle(2);

        // FWFT: streaming write+pop each cycle
        for (int i = 0; i < 4; i++) f_op(1, 8'h40 + 8'(i), 0);
        idle(2);
        for (int i = 0; i < 20; i++) f_op(1, 8'h60 + 8'(i), 1);
        for (int i = 0; i < 5; i++) f_op(0, 8'h00, 1);
        idle(2);

        // FWFT: full with simultaneous write and pop
        for (int i = 0; i < DEPTH; i++) f_op(1, 8'(i) ^ 8'hC6, 0);
        idle(3);
        f_op(1, 8'hEE, 1);
        f_op(1, 8'hEF, 0);
        for (int i = 0; i < DEPTH; i++) f_op(0, 8'h00, 1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
